// File: rtl/palindrome_rr_sched.sv
// Round-robin scheduler sharing one serial 3-bit palindrome checker among NUM_REQ requesters.
// Optional macro PAL_SCHED_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module palindrome_rr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 8,
  localparam int unsigned HIT_W  = $clog2(WORD_W - 1),
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [HIT_W-1:0]          rsp_hits,
  output logic                      rsp_all,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RESP} state_t;

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [1:0]        hist;
  logic [1:0]        fill;
  logic [HIT_W-1:0]  hits;
  logic [CNT_W-1:0]  bit_cnt;

  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  logic [WORD_W-1:0] win_word;
  logic              cur_bit;
  logic              hit_now;
  logic [HIT_W-1:0]  hits_next;

`ifndef PAL_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]   rr_ptr;
`endif

  // Arbitration: first valid requester searching upward from the rr pointer (or from 0).
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    cand     = '0;
    win_word = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef PAL_SCHED_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        win_id   = cand;
        win_word = req_data[cand*WORD_W +: WORD_W];
      end
    end
  end

  // Grant is combinational so the requester sees ready in the accept cycle.
  always_comb begin
    req_ready = '0;
    if (reset && state == ST_IDLE && found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Serial checker: a bit closes a palindromic window when it equals the bit two places back.
  always_comb begin
    cur_bit   = word_q[WORD_W-1];
    hit_now   = fill[1] & (cur_bit == hist[1]);
    hits_next = hits + HIT_W'(hit_now);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      hist      <= '0;
      fill      <= '0;
      hits      <= '0;
      bit_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_hits  <= '0;
      rsp_all   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            word_q  <= win_word;
            rsp_id  <= win_id;
            hist    <= '0;
            fill    <= '0;
            hits    <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          word_q <= word_q << 1;
          hist   <= {hist[0], cur_bit};
          hits   <= hits_next;
          if (!fill[1]) begin
            fill <= fill + 2'd1;
          end
          if (bit_cnt == CNT_W'(WORD_W - 1)) begin
            rsp_valid <= 1'b1;
            rsp_hits  <= hits_next;
            rsp_all   <= (hits_next == HIT_W'(WORD_W - 2));
            state     <= ST_RESP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef PAL_SCHED_FIXED_PRIO_EN
  // Pointer moves past the owner of the word whose response was just taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (state == ST_RESP && rsp_ready) begin
      rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_palindrome_rr_sched.sv
// Self-checking bench for palindrome_rr_sched: per-cycle behavioural model plus directed literal checks.
module tb_palindrome_rr_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WORD_W  = 8;
  localparam int unsigned HIT_W   = 3;
  localparam int unsigned ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*WORD_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [ID_W-1:0]           rsp_id;
  logic [HIT_W-1:0]          rsp_hits;
  logic                      rsp_all;
  logic                      busy;

  palindrome_rr_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_hits(rsp_hits), .rsp_all(rsp_all), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Count of palindromic 3-bit windows, MSB-first.
  function automatic int pal_hits(input logic [WORD_W-1:0] w);
    int h = 0;
    for (int i = WORD_W - 1; i >= 2; i--) if (w[i] == w[i-2]) h++;
    return h;
  endfunction

  function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Model: 0 = idle, 1 = working (timer counts remaining bits), 2 = response pending.
  int m_state = 0, m_timer = 0, m_ptr = 0, m_id = 0, m_hits = 0;
  int acc_id[$], acc_cyc[$], rise_cyc[$];
  int rq_id[$], rq_hits[$], rq_all[$];
  logic prev_rv = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      m_ptr   = 0;
      prev_rv = 1'b0;
    end else begin
      if (rsp_valid && !prev_rv) rise_cyc.push_back(cyc);
      prev_rv = rsp_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rq_id.push_back(int'(rsp_id));
        rq_hits.push_back(int'(rsp_hits));
        rq_all.push_back(int'(rsp_all));
      end
      case (m_state)
        0: begin
          int w;
          w = pick(m_ptr, req_valid);
          if (w >= 0) begin
            m_id    = w;
            m_hits  = pal_hits(req_data[w*WORD_W +: WORD_W]);
            m_timer = WORD_W;
            m_state = 1;
          end
        end
        1: begin
          m_timer--;
          if (m_timer == 0) m_state = 2;
        end
        default: begin
          if (rsp_ready) begin
`ifndef PAL_SCHED_FIXED_PRIO_EN
            m_ptr = (m_id + 1) % NUM_REQ;
`endif
            m_state = 0;
          end
        end
      endcase
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int w;
    exp_rdy = '0;
    if (reset && m_state == 0) begin
      w = pick(m_ptr, req_valid);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
    chk("busy", 32'(busy), 32'(m_state != 0));
    if (m_state == 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_hits", 32'(rsp_hits), 32'(m_hits));
      chk("rsp_all", 32'(rsp_all), 32'(m_hits == WORD_W - 2));
    end
    if (!reset) begin
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_rsp_hits", 32'(rsp_hits), 32'd0);
      chk("reset_rsp_all", 32'(rsp_all), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [WORD_W-1:0] w, input bit drop);
    bit got = 1'b0;
    int n = 0;
    req_data[idx*WORD_W +: WORD_W] = w;
    req_valid[idx] = 1'b1;
    while (!got && n < 60) begin
      @(posedge clk);
      if (req_ready[idx]) got = 1'b1;
      n++;
      #1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    if (drop) req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      if (rsp_valid && rsp_ready) got = 1'b1;
      n++;
      #1;
    end
    if (!got) chk("response_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_last(input string name, input int id, input int hits, input int all);
    if (rq_id.size() == 0) begin
      chk({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_id"}, 32'(rq_id[$]), 32'(id));
      chk({name, "_hits"}, 32'(rq_hits[$]), 32'(hits));
      chk({name, "_all"}, 32'(rq_all[$]), 32'(all));
    end
  endtask

  initial begin
    int base;
    int nb;
    int bound;
    logic [HIT_W-1:0] held_hits;

    repeat (3) tick();
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();

    // Alternating word: every window palindromic, fixed latency.
    send(0, 8'b10101010, 1'b1);
    wait_rsp();
    check_last("t1", 0, 6, 1);
    if (acc_cyc.size() > 0 && rise_cyc.size() > 0)
      chk("t1_latency", 32'(rise_cyc[0] - acc_cyc[0]), 32'd9);
    else
      chk("t1_latency_missing", 32'd0, 32'd1);

    send(2, 8'b11001010, 1'b1); wait_rsp(); check_last("t2a", 2, 3, 0);
    send(2, 8'b11100100, 1'b1); wait_rsp(); check_last("t2b", 2, 2, 0);
    send(2, 8'b00000000, 1'b1); wait_rsp(); check_last("t2c", 2, 6, 1);
    send(3, 8'b01101001, 1'b1); wait_rsp(); check_last("t3", 3, 2, 0);

    // All requesters continuously valid from reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base = acc_id.size();
    req_data = {8'b01101001, 8'b11100100, 8'b11001010, 8'b10101010};
    req_valid = 4'b1111;
    bound = 0;
    while (acc_id.size() < base + 5 && bound < 100) begin
      tick();
      bound++;
    end
    req_valid = '0;
    if (acc_id.size() < base + 5) begin
      chk("t4_accept_timeout", 32'd0, 32'd1);
    end else begin
      for (int j = 0; j < 5; j++) begin
`ifdef PAL_SCHED_FIXED_PRIO_EN
        chk("t4_order", 32'(acc_id[base+j]), 32'd0);
`else
        chk("t4_order", 32'(acc_id[base+j]), 32'(j % 4));
`endif
      end
      for (int j = 0; j < 4; j++)
        chk("t4_spacing", 32'(acc_cyc[base+j+1] - acc_cyc[base+j]), 32'd10);
    end
    wait_rsp();

    // Back-pressure in response state.
    rsp_ready = 1'b0;
    send(1, 8'b11100100, 1'b1);
    bound = 0;
    while (!rsp_valid && bound < 40) begin
      tick();
      bound++;
    end
    chk("t5_rsp_seen", 32'(rsp_valid), 32'd1);
    held_hits = rsp_hits;
    req_data[3*WORD_W +: WORD_W] = 8'b10101010;
    req_valid[3] = 1'b1;
    nb = rq_id.size();
    repeat (5) tick();
    chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
    chk("t5_hold_hits", 32'(rsp_hits), 32'(held_hits));
    chk("t5_hold_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("t5_single_handshake", 32'(rq_id.size() - nb), 32'd1);
    check_last("t5", 1, 2, 0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Reset while shifting bit 4; requester 1 stays valid.
    nb = rq_id.size();
    send(1, 8'b01011010, 1'b0);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    base = acc_id.size();
    send(1, 8'b01011010, 1'b1);
    if (acc_id.size() > base) chk("t6_regrant", 32'(acc_id[$]), 32'd1);
    else chk("t6_regrant_missing", 32'd0, 32'd1);
    wait_rsp();
    chk("t6_one_response", 32'(rq_id.size() - nb), 32'd1);
    check_last("t6", 1, 4, 0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
